kyber_encrypt_core: RTL and testbench
=====================================

// Module: kyber_encrypt_core
// PURPOSE
//  Baby-Kyber encryption stage, directly downstream of key generation; consumes the public key (A, t).
//  Computes u = A^T*r + e1 and v = t^T*r + e2 + msg*ceil(Q/2) over Z_Q[x]/(x^N+1).
//  Uses one sequential coefficient MAC per cycle under a small FSM, and emits the ciphertext (u, v) with a done pulse.
// PARAMETERS
//  Q   17  modulus; all outputs are in [0,Q-1]
//  N   4   coefficients per polynomial
//  K   2   module rank (vector length)
//  CW  32  input/output coefficient width in bits
// PORTS
//  clk     in   1          rising-edge clock
//  rst_n   in   1          asynchronous active-low reset
//  start   in   1          request; sampled only in IDLE
//  a_flat  in   K*K*N*CW   A[row][col][c] at [((row*K+col)*N+c)*CW +: CW]
//  t_flat  in   K*N*CW     t[j][c] at [(j*N+c)*CW +: CW]
//  r_flat  in   K*N*CW     r[j][c], same packing as t
//  e1_flat in   K*N*CW     e1[i][c], same packing as t
//  e2_flat in   N*CW       e2[c] at [c*CW +: CW]
//  msg     in   N          message bit per coefficient; bit c -> v coefficient c
//  busy    out  1          high from the accepting edge until done
//  done    out  1          one-cycle pulse; u_flat/v_flat are valid from this cycle on
//  u_flat  out  K*N*CW     u[i][c], same packing as t; zero-extended residues
//  v_flat  out  N*CW       v[c]; zero-extended residues
// BEHAVIOUR
//  Reset: FSM=IDLE; busy=0, done=0, u_flat=0, v_flat=0; accumulators and captured operands cleared.
//  FSM states: IDLE -> LOAD -> MAC_U -> MAC_V -> FIN -> IDLE.
//  IDLE: start=1 at an edge -> LOAD; busy rises at that edge. start is ignored in every other state.
//  LOAD (1 cycle): all inputs are captured and each coefficient is reduced mod Q (unsigned). Accumulators are zeroed.
//   Inputs need only be stable on the edge that accepts start; later changes have no effect.
//  MAC_U: K*K*N*N cycles. Loop order is i (u index), j, a (A coefficient), b (r coefficient), innermost last.
//   Each cycle: p = A[j][i][a]*r[j][b] mod Q; k = a+b.
//   If k<N then acc_u[i][k] += p, else acc_u[i][k-N] -= p. The negacyclic wrap is x^N = -1; all results are kept in [0,Q-1].
//  MAC_V: K*N*N cycles; same loop over j, a, b using t[j][a]*r[j][b] into acc_v.
//  FIN (1 cycle): u[i][c] = (acc_u[i][c] + e1[i][c]) mod Q; v[c] = (acc_v[c] + e2[c] + msg[c]*((Q+1)/2)) mod Q.
//   Outputs are registered; done=1 and busy=0 take effect at the same edge; next state is IDLE.
//  Latency: done is high in the cycle after edge 2 + K*N*N*(K+1), counted from the accepting edge (edge 0).
//   With default parameters done is high after edge 98. A new start is accepted in the cycle following done.
//  u_flat/v_flat hold their values until the next done or reset. They never show partial results.
//  No intermediate value exceeds 2*CW bits: products are reduced before they are accumulated.
//  Reset asserted mid-operation: immediate return to the reset state; no done is issued.
// CONFIGURATION
//  KYBER_ENC_ABORT_EN defined:
//   - Adds input port 'abort' (1 bit).
//   - abort=1 at an edge while busy -> IDLE at that edge; busy=0, no done, u_flat/v_flat unchanged.
//   - abort has no effect in IDLE; if start and abort are both high in IDLE, start is accepted.
//  KYBER_ENC_ABORT_EN undefined: the 'abort' port does not exist; every accepted start runs to done.
// TESTING
//  1. A, t, r = 0; every e1 coefficient = 1; e2 = 2; msg = 4'b1010 -> u all 1; v = {c0:2, c1:11, c2:2, c3:11}.
//  2. A[0][0] = x^3 (coef3 = 1), r[0] = x (coef1 = 1), all else 0 -> u[0] = {16,0,0,0}, u[1] = 0, v = 0 (negacyclic wrap).
//  3. All inputs zero except e1[1][2] = 35 and e2[3] = 40 -> u[1][2] = 1, v[3] = 6 (input reduction).
//  4. Start at edge 0, start held high through edge 98 -> busy for edges 0..97, done only after edge 98, no second run before IDLE.
//  5. rst_n low at cycle 40 of a run -> busy=0, u/v=0, no done; a fresh start then completes in 98 cycles.
//  6. (KYBER_ENC_ABORT_EN) abort at cycle 50 -> busy=0, no done, previous u/v retained; t = 0, r = 1, A = 0 -> all-zero u/v apart from the e1/e2/msg terms.

Source files
------------

// File: rtl/kyber_encrypt_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : kyber_encrypt_core                                            |
// | Function : Baby-Kyber encryption, u = A^T*r + e1, v = t^T*r + e2 + m*Q/2 |
// |            over Z_Q[x]/(x^N+1), one coefficient MAC per cycle.           |
// | Option   : KYBER_ENC_ABORT_EN adds an 'abort' input that cancels a run.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module kyber_encrypt_core #(
    parameter int Q  = 17,
    parameter int N  = 4,
    parameter int K  = 2,
    parameter int CW = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef KYBER_ENC_ABORT_EN
    input  logic                  abort,
`endif
    input  logic [K*K*N*CW-1:0]   a_flat,
    input  logic [K*N*CW-1:0]     t_flat,
    input  logic [K*N*CW-1:0]     r_flat,
    input  logic [K*N*CW-1:0]     e1_flat,
    input  logic [N*CW-1:0]       e2_flat,
    input  logic [N-1:0]          msg,
    output logic                  busy,
    output logic                  done,
    output logic [K*N*CW-1:0]     u_flat,
    output logic [N*CW-1:0]       v_flat
);

    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    localparam logic [CW-1:0]   c_q      = CW'(Q);
    localparam logic [2*CW-1:0] c_q_w    = (2*CW)'(Q);
    localparam logic [CW-1:0]   c_half   = CW'((Q + 1) / 2);
    localparam logic [NW:0]     c_n      = (NW+1)'(N);
    localparam logic [NW-1:0]   c_n_last = NW'(N - 1);
    localparam logic [KW-1:0]   c_k_last = KW'(K - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MAC_U = 3'd2;
    localparam logic [2:0] S_MAC_V = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;

    logic [CW-1:0] r_a   [K][K][N];
    logic [CW-1:0] r_t   [K][N];
    logic [CW-1:0] r_r   [K][N];
    logic [CW-1:0] r_e1  [K][N];
    logic [CW-1:0] r_e2  [N];
    logic [N-1:0]  r_msg;
    logic [CW-1:0] r_acc_u [K][N];
    logic [CW-1:0] r_acc_v [N];

    logic [KW-1:0] r_ci, r_cj;
    logic [NW-1:0] r_ca, r_cb;

    logic [K*N*CW-1:0] r_u_flat;
    logic [N*CW-1:0]   r_v_flat;
    logic              r_done;

    logic w_capture, w_load, w_mac_u, w_mac_v, w_fin, w_abort, w_last_jab;

    logic [CW-1:0]   w_op_x, w_op_y, w_prod, w_acc_cur, w_acc_new;
    logic [2*CW-1:0] w_prod_full;
    logic [NW:0]     w_sum;
    logic            w_wrap;
    logic [NW-1:0]   w_kidx;

`ifdef KYBER_ENC_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    function automatic logic [CW-1:0] f_mod_q(input logic [CW-1:0] x);
        return x % c_q;
    endfunction

    // Both operands are already residues, so one conditional subtract suffices.
    function automatic logic [CW-1:0] f_add_q(input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic [CW:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, c_q})
            s = s - {1'b0, c_q};
        return s[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] f_sub_q(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return (x >= y) ? (x - y) : (x + c_q - y);
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    assign w_last_jab = (r_cb == c_n_last) && (r_ca == c_n_last) && (r_cj == c_k_last);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_MAC_U;
            S_MAC_U: if (w_last_jab && (r_ci == c_k_last)) w_state_nxt = S_MAC_V;
            S_MAC_V: if (w_last_jab) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort && (r_state != S_IDLE))
            w_state_nxt = S_IDLE;
    end

    // Output / strobe decode
    always_comb begin
        busy      = 1'b0;
        w_capture = 1'b0;
        w_load    = 1'b0;
        w_mac_u   = 1'b0;
        w_mac_v   = 1'b0;
        w_fin     = 1'b0;
        case (r_state)
            S_IDLE:  w_capture = start;
            S_LOAD:  begin busy = 1'b1; w_load  = 1'b1; end
            S_MAC_U: begin busy = 1'b1; w_mac_u = 1'b1; end
            S_MAC_V: begin busy = 1'b1; w_mac_v = 1'b1; end
            S_FIN:   begin busy = 1'b1; w_fin   = !w_abort; end
            default: busy = 1'b0;
        endcase
    end

    // Operands are latched raw on the accepting edge and reduced in place during LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int x = 0; x < K; x++) begin
                for (int y = 0; y < K; y++)
                    for (int c = 0; c < N; c++)
                        r_a[x][y][c] <= '0;
                for (int c = 0; c < N; c++) begin
                    r_t[x][c]  <= '0;
                    r_r[x][c]  <= '0;
                    r_e1[x][c] <= '0;
                end
            end
            for (int c = 0; c < N; c++)
                r_e2[c] <= '0;
            r_msg <= '0;
        end else if (w_capture) begin
            for (int x = 0; x < K; x++) begin
                for (int y = 0; y < K; y++)
                    for (int c = 0; c < N; c++)
                        r_a[x][y][c] <= a_flat[((x*K+y)*N+c)*CW +: CW];
                for (int c = 0; c < N; c++) begin
                    r_t[x][c]  <= t_flat[(x*N+c)*CW +: CW];
                    r_r[x][c]  <= r_flat[(x*N+c)*CW +: CW];
                    r_e1[x][c] <= e1_flat[(x*N+c)*CW +: CW];
                end
            end
            for (int c = 0; c < N; c++)
                r_e2[c] <= e2_flat[c*CW +: CW];
            r_msg <= msg;
        end else if (w_load) begin
            for (int x = 0; x < K; x++) begin
                for (int y = 0; y < K; y++)
                    for (int c = 0; c < N; c++)
                        r_a[x][y][c] <= f_mod_q(r_a[x][y][c]);
                for (int c = 0; c < N; c++) begin
                    r_t[x][c]  <= f_mod_q(r_t[x][c]);
                    r_r[x][c]  <= f_mod_q(r_r[x][c]);
                    r_e1[x][c] <= f_mod_q(r_e1[x][c]);
                end
            end
            for (int c = 0; c < N; c++)
                r_e2[c] <= f_mod_q(r_e2[c]);
        end
    end

    // Loop counters, innermost r_cb; i only advances while computing u.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ci <= '0;
            r_cj <= '0;
            r_ca <= '0;
            r_cb <= '0;
        end else if (w_load) begin
            r_ci <= '0;
            r_cj <= '0;
            r_ca <= '0;
            r_cb <= '0;
        end else if (w_mac_u || w_mac_v) begin
            if (r_cb == c_n_last) begin
                r_cb <= '0;
                if (r_ca == c_n_last) begin
                    r_ca <= '0;
                    if (r_cj == c_k_last) begin
                        r_cj <= '0;
                        if (w_mac_u)
                            r_ci <= (r_ci == c_k_last) ? '0 : r_ci + 1'b1;
                    end else begin
                        r_cj <= r_cj + 1'b1;
                    end
                end else begin
                    r_ca <= r_ca + 1'b1;
                end
            end else begin
                r_cb <= r_cb + 1'b1;
            end
        end
    end

    // Single MAC datapath; the product is reduced before it reaches an accumulator.
    assign w_op_x      = w_mac_v ? r_t[r_cj][r_ca] : r_a[r_cj][r_ci][r_ca];
    assign w_op_y      = r_r[r_cj][r_cb];
    assign w_prod_full = {{CW{1'b0}}, w_op_x} * {{CW{1'b0}}, w_op_y};
    assign w_prod      = CW'(w_prod_full % c_q_w);
    assign w_sum       = {1'b0, r_ca} + {1'b0, r_cb};
    assign w_wrap      = (w_sum >= c_n);
    assign w_kidx      = w_wrap ? NW'(w_sum - c_n) : w_sum[NW-1:0];
    assign w_acc_cur   = w_mac_v ? r_acc_v[w_kidx] : r_acc_u[r_ci][w_kidx];
    // x^N = -1: terms landing past degree N-1 are subtracted.
    assign w_acc_new   = w_wrap ? f_sub_q(w_acc_cur, w_prod) : f_add_q(w_acc_cur, w_prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int x = 0; x < K; x++)
                for (int c = 0; c < N; c++)
                    r_acc_u[x][c] <= '0;
            for (int c = 0; c < N; c++)
                r_acc_v[c] <= '0;
        end else if (w_load) begin
            for (int x = 0; x < K; x++)
                for (int c = 0; c < N; c++)
                    r_acc_u[x][c] <= '0;
            for (int c = 0; c < N; c++)
                r_acc_v[c] <= '0;
        end else if (w_mac_u) begin
            r_acc_u[r_ci][w_kidx] <= w_acc_new;
        end else if (w_mac_v) begin
            r_acc_v[w_kidx] <= w_acc_new;
        end
    end

    // Ciphertext registers only change on the finishing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_u_flat <= '0;
            r_v_flat <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_fin) begin
                for (int x = 0; x < K; x++)
                    for (int c = 0; c < N; c++)
                        r_u_flat[(x*N+c)*CW +: CW] <= f_add_q(r_acc_u[x][c], r_e1[x][c]);
                for (int c = 0; c < N; c++)
                    r_v_flat[c*CW +: CW] <= f_add_q(f_add_q(r_acc_v[c], r_e2[c]),
                                                    r_msg[c] ? c_half : '0);
            end
        end
    end

    assign done   = r_done;
    assign u_flat = r_u_flat;
    assign v_flat = r_v_flat;

endmodule
`default_nettype wire

// File: tb/tb_kyber_encrypt_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_kyber_encrypt_core                                         |
// | Function : Bench for kyber_encrypt_core with a polynomial-level model.   |
// | Option   : KYBER_ENC_ABORT_EN enables the abort scenario.                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_kyber_encrypt_core;

    localparam int Q   = 17;
    localparam int N   = 4;
    localparam int K   = 2;
    localparam int CW  = 32;
    localparam int LAT = 2 + K*N*N*(K+1);
    localparam int AW  = K*K*N*CW;
    localparam int UW  = K*N*CW;
    localparam int VW  = N*CW;

    logic          clk, rst_n, start;
    logic [AW-1:0] a_flat;
    logic [UW-1:0] t_flat, r_flat, e1_flat;
    logic [VW-1:0] e2_flat;
    logic [N-1:0]  msg;
    logic          busy, done;
    logic [UW-1:0] u_flat;
    logic [VW-1:0] v_flat;
    logic          m_abort;
`ifdef KYBER_ENC_ABORT_EN
    logic          abort;
    assign m_abort = abort;
`else
    assign m_abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    kyber_encrypt_core #(.Q(Q), .N(N), .K(K), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
`ifdef KYBER_ENC_ABORT_EN
        .abort   (abort),
`endif
        .a_flat  (a_flat),
        .t_flat  (t_flat),
        .r_flat  (r_flat),
        .e1_flat (e1_flat),
        .e2_flat (e2_flat),
        .msg     (msg),
        .busy    (busy),
        .done    (done),
        .u_flat  (u_flat),
        .v_flat  (v_flat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Schoolbook negacyclic polynomial products over plain integers.
    function automatic logic [UW-1:0] model_u(input logic [AW-1:0] a, input logic [UW-1:0] r,
                                              input logic [UW-1:0] e1);
        logic [UW-1:0] res;
        longint acc [N];
        longint p;
        int unsigned av, rv;
        res = '0;
        for (int i = 0; i < K; i++) begin
            for (int c = 0; c < N; c++) acc[c] = 0;
            for (int j = 0; j < K; j++)
                for (int x = 0; x < N; x++)
                    for (int y = 0; y < N; y++) begin
                        av = a[((j*K+i)*N+x)*CW +: CW] % Q;
                        rv = r[(j*N+y)*CW +: CW] % Q;
                        p  = longint'(av) * longint'(rv);
                        if (x + y < N) acc[x+y] += p;
                        else           acc[x+y-N] -= p;
                    end
            for (int c = 0; c < N; c++) begin
                av = e1[(i*N+c)*CW +: CW] % Q;
                acc[c] += longint'(av);
                res[(i*N+c)*CW +: CW] = CW'(((acc[c] % Q) + Q) % Q);
            end
        end
        return res;
    endfunction

    function automatic logic [VW-1:0] model_v(input logic [UW-1:0] t, input logic [UW-1:0] r,
                                              input logic [VW-1:0] e2, input logic [N-1:0] m);
        logic [VW-1:0] res;
        longint acc [N];
        int unsigned tv, rv;
        res = '0;
        for (int c = 0; c < N; c++) acc[c] = 0;
        for (int j = 0; j < K; j++)
            for (int x = 0; x < N; x++)
                for (int y = 0; y < N; y++) begin
                    tv = t[(j*N+x)*CW +: CW] % Q;
                    rv = r[(j*N+y)*CW +: CW] % Q;
                    if (x + y < N) acc[x+y] += longint'(tv) * longint'(rv);
                    else           acc[x+y-N] -= longint'(tv) * longint'(rv);
                end
        for (int c = 0; c < N; c++) begin
            tv = e2[c*CW +: CW] % Q;
            acc[c] += longint'(tv) + (m[c] ? longint'((Q + 1) / 2) : 0);
            res[c*CW +: CW] = CW'(((acc[c] % Q) + Q) % Q);
        end
        return res;
    endfunction

    // Transaction-level model: a run takes LAT edges from acceptance, then publishes.
    logic          m_busy, m_done;
    int            m_cnt;
    logic [UW-1:0] m_u, p_u;
    logic [VW-1:0] m_v, p_v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_u    <= '0;
            m_v    <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_abort) begin
                    m_busy <= 1'b0;
                end else if (m_cnt == LAT) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_u    <= p_u;
                    m_v    <= p_v;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                p_u    <= model_u(a_flat, r_flat, e1_flat);
                p_v    <= model_v(t_flat, r_flat, e2_flat, msg);
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (busy !== m_busy || done !== m_done || u_flat !== m_u || v_flat !== m_v) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t busy=%b want %b done=%b want %b u=%h want %h v=%h want %h",
                     $time, busy, m_busy, done, m_done, u_flat, m_u, v_flat, m_v);
        end
    end

    task automatic check_vec(input string name, input logic [UW-1:0] act, input logic [UW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        a_flat = '0; t_flat = '0; r_flat = '0; e1_flat = '0; e2_flat = '0; msg = '0;
    endtask

    task automatic randomize_inputs();
        for (int w = 0; w < AW/32; w++) a_flat[w*32 +: 32] = $urandom();
        for (int w = 0; w < UW/32; w++) begin
            t_flat[w*32 +: 32]  = $urandom();
            r_flat[w*32 +: 32]  = $urandom();
            e1_flat[w*32 +: 32] = $urandom();
        end
        for (int w = 0; w < VW/32; w++) e2_flat[w*32 +: 32] = $urandom();
        msg = N'($urandom());
    endtask

    // Pulse start for one edge, optionally disturb inputs, and time the run to done.
    task automatic run_op(input string name, input bit scramble);
        int n;
        bit seen;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        if (scramble) randomize_inputs();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = (done === 1'b1);
        end
        check_int({name, "_latency"}, seen ? n : -1, 98);
    endtask

    initial begin
        logic [UW-1:0] eu;
        logic [VW-1:0] ev;
        rst_n = 1'b1;
        start = 1'b0;
`ifdef KYBER_ENC_ABORT_EN
        abort = 1'b0;
`endif
        clear_inputs();
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        check_vec("reset_u", u_flat, '0);
        check_vec("reset_v", UW'(v_flat), '0);
        #2 rst_n = 1'b1;

        // Only the noise and message terms contribute.
        clear_inputs();
        for (int w = 0; w < K*N; w++) e1_flat[w*CW +: CW] = 1;
        for (int c = 0; c < N; c++)   e2_flat[c*CW +: CW] = 2;
        msg = 4'b1010;
        eu = '0;
        for (int w = 0; w < K*N; w++) eu[w*CW +: CW] = 1;
        ev = {32'd11, 32'd2, 32'd11, 32'd2};
        check_vec("model_t1_v", UW'(model_v(t_flat, r_flat, e2_flat, msg)), UW'(ev));
        run_op("t1", 1'b1);
        check_vec("t1_u", u_flat, eu);
        check_vec("t1_v", UW'(v_flat), UW'(ev));

        // x^3 * x wraps to -1 in coefficient 0.
        clear_inputs();
        a_flat[3*CW +: CW] = 1;
        r_flat[1*CW +: CW] = 1;
        eu = '0;
        eu[0 +: CW] = 16;
        check_vec("model_t2_u", model_u(a_flat, r_flat, e1_flat), eu);
        run_op("t2", 1'b0);
        check_vec("t2_u", u_flat, eu);
        check_vec("t2_v", UW'(v_flat), '0);

        // Raw inputs above Q are reduced.
        clear_inputs();
        e1_flat[6*CW +: CW] = 35;
        e2_flat[3*CW +: CW] = 40;
        eu = '0;
        eu[6*CW +: CW] = 1;
        ev = '0;
        ev[3*CW +: CW] = 6;
        run_op("t3", 1'b0);
        check_vec("t3_u", u_flat, eu);
        check_vec("t3_v", UW'(v_flat), UW'(ev));

        // start held through the finishing edge must not restart the core.
        randomize_inputs();
        @(negedge clk) start = 1'b1;
        repeat (99) @(posedge clk);
        @(negedge clk);
        check_int("t4_done_at_98", int'(done), 1);
        check_int("t4_busy_at_98", int'(busy), 0);
        start = 1'b0;
        @(negedge clk);
        check_int("t4_no_rerun", int'(busy), 0);

        // Reset in the middle of a run.
        randomize_inputs();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_int("t5_busy", int'(busy), 0);
        check_int("t5_done", int'(done), 0);
        check_vec("t5_u", u_flat, '0);
        check_vec("t5_v", UW'(v_flat), '0);
        #2 rst_n = 1'b1;
        randomize_inputs();
        run_op("t5_fresh", 1'b0);

`ifdef KYBER_ENC_ABORT_EN
        clear_inputs();
        randomize_inputs();
        a_flat = '0;
        t_flat = '0;
        r_flat = '0;
        for (int j = 0; j < K; j++) r_flat[j*N*CW +: CW] = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check_int("t6_abort_busy", int'(busy), 0);
        check_int("t6_abort_done", int'(done), 0);
        run_op("t6_run", 1'b0);
`endif

        for (int k = 0; k < 6; k++) begin
            randomize_inputs();
            run_op("rand", 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
